// File: rtl/vga_frame_src.sv
// Raster-order test-pattern source: streams {colour, start} words for one frame per enabled period.
// Optional macro VGA_FRAME_SRC_BORDER_EN forces a one-pixel white frame border over the pattern.
module vga_frame_src #(
    parameter int CD = 12,
    parameter int HD = 640,
    parameter int VD = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [1:0]    pattern_sel,
    input  logic [CD-1:0] fg_color,
    output logic [CD:0]   vga_so_data,
    output logic          vga_so_valid,
    input  logic          vga_so_ready,
    output logic [15:0]   frame_count,
    output logic          busy
);

    localparam int CW = CD / 3;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_reg, state_next;
    logic [9:0]    x_reg, x_next;
    logic [8:0]    y_reg, y_next;
    logic [1:0]    pat_reg, pat_next;
    logic [CD-1:0] fg_reg, fg_next;
    logic [CD:0]   data_reg, data_next;
    logic          valid_reg, valid_next;
    logic [15:0]   fc_reg, fc_next;
    logic          load;
    logic          start_next;
    logic [2:0]    bar;
    logic [CD-1:0] pix;

    // Bar index x/80 resolved with threshold compares instead of a divider.
    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (x_next >= 10'(i * 80)) bar = 3'(i);
        end
    end

    // Colour of the pixel about to be loaded, from the next coordinates and controls.
    always_comb begin
        pix = '0;
        unique case (pat_next)
            2'd0: pix = fg_next;
            2'd1: pix = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
            2'd2: pix = (x_next[5] ^ y_next[5]) ? fg_next : '0;
            default: pix = {3{x_next[9 -: CW]}};
        endcase
`ifdef VGA_FRAME_SRC_BORDER_EN
        if (x_next == 10'd0 || x_next == 10'(HD - 1) ||
            y_next == 9'd0  || y_next == 9'(VD - 1)) begin
            pix = '1;
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        pat_next   = pat_reg;
        fg_next    = fg_reg;
        valid_next = valid_reg;
        fc_next    = fc_reg;
        load       = 1'b0;
        start_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                valid_next = 1'b0;
                if (enable) begin
                    pat_next   = pattern_sel;
                    fg_next    = fg_color;
                    x_next     = '0;
                    y_next     = '0;
                    load       = 1'b1;
                    start_next = 1'b1;
                    valid_next = 1'b1;
                    state_next = STREAM;
                end
            end
            default: begin
                if (vga_so_ready) begin
                    if (x_reg == 10'(HD - 1)) begin
                        x_next = '0;
                        if (y_reg == 9'(VD - 1)) begin
                            y_next  = '0;
                            fc_next = fc_reg + 16'd1;
                            // Back-to-back frames reload (0,0) on the same edge, so valid never drops.
                            if (enable) begin
                                pat_next   = pattern_sel;
                                fg_next    = fg_color;
                                load       = 1'b1;
                                start_next = 1'b1;
                            end else begin
                                valid_next = 1'b0;
                                state_next = IDLE;
                            end
                        end else begin
                            y_next = y_reg + 9'd1;
                            load   = 1'b1;
                        end
                    end else begin
                        x_next = x_reg + 10'd1;
                        load   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        data_next = data_reg;
        if (load) begin
            data_next = {pix, start_next};
        end else if (state_next == IDLE) begin
            data_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            pat_reg   <= '0;
            fg_reg    <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            fc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            pat_reg   <= pat_next;
            fg_reg    <= fg_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            fc_reg    <= fc_next;
        end
    end

    assign vga_so_data  = data_reg;
    assign vga_so_valid = valid_reg;
    assign frame_count  = fc_reg;
    assign busy         = (state_reg == STREAM);

endmodule
